// File: rtl/lsu_wb_master.sv
// Load/store unit driving Wishbone-classic cycles into a word-addressed, byte-selectable RAM.
// Optional macro LSU_MISALIGN_SPLIT_EN: when defined, word-crossing accesses are split into two bus cycles.
module lsu_wb_master #(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [31:0]       req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   output logic [31:0]       resp_rdata,
   output logic              resp_err,
   output logic              wb_cyc,
   output logic              wb_stb,
   output logic              wb_we,
   output logic [3:0]        wb_sel,
   output logic [ADDR_W-1:0] wb_adr,
   output logic [31:0]       wb_dat_o,
   input  logic [31:0]       wb_dat_i,
   input  logic              wb_ack
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUS1 = 2'd1,
      BUS2 = 2'd2,
      RESP = 2'd3
   } state_t;

   state_t state_r, state_nx_s;

   logic              we_r, we_nx_s;
   logic [1:0]        size_r, size_nx_s;
   logic              uns_r, uns_nx_s;
   logic [1:0]        off_r, off_nx_s;
   logic [ADDR_W-1:0] adr_r, adr_nx_s;
   logic [31:0]       wdata_r, wdata_nx_s;
   logic              err_r, err_nx_s;
   logic              cross_r, cross_nx_s;
   logic [31:0]       rd1_r, rd1_nx_s;
   logic [31:0]       rd2_r, rd2_nx_s;

   logic              accept_s;
   logic              req_cross_s;
   logic              req_err_s;

   logic              req_ready_s, resp_valid_s, resp_err_s;
   logic [31:0]       resp_rdata_s;
   logic              cyc_s, stb_s, we_s;
   logic [3:0]        sel_s;
   logic [ADDR_W-1:0] adr_s;
   logic [31:0]       dat_s;
   logic [7:0]        lane_s;
   logic [63:0]       wide_s;
   logic [31:0]       ld_s;
   logic [31:0]       ext_s;

   function automatic logic [3:0] size_mask(input logic [1:0] size);
      case (size)
         2'd0:    size_mask = 4'b0001;
         2'd1:    size_mask = 4'b0011;
         2'd2:    size_mask = 4'b1111;
         default: size_mask = 4'b0000;
      endcase
   endfunction

   assign accept_s = (state_r == IDLE) && req_valid;

   // Classify the incoming request: word crossing and fault detection
   always_comb begin
      req_cross_s = 1'b0;
      case (req_size)
         2'd1:    req_cross_s = (req_addr[1:0] == 2'd3);
         2'd2:    req_cross_s = (req_addr[1:0] != 2'd0);
         default: req_cross_s = 1'b0;
      endcase
`ifdef LSU_MISALIGN_SPLIT_EN
      // a split must not wrap past the top word of the RAM
      req_err_s = (req_size == 2'd3) || ((req_addr >> (ADDR_W + 2)) != 32'd0) ||
                  (req_cross_s && (&req_addr[ADDR_W+1:2]));
`else
      req_err_s = (req_size == 2'd3) || ((req_addr >> (ADDR_W + 2)) != 32'd0) || req_cross_s ||
                  ((req_size == 2'd1) && req_addr[0]);
`endif
   end

   // Next values of the request context and captured read words
   always_comb begin
      we_nx_s    = we_r;
      size_nx_s  = size_r;
      uns_nx_s   = uns_r;
      off_nx_s   = off_r;
      adr_nx_s   = adr_r;
      wdata_nx_s = wdata_r;
      err_nx_s   = err_r;
      cross_nx_s = cross_r;
      rd1_nx_s   = rd1_r;
      rd2_nx_s   = rd2_r;
      if (accept_s) begin
         we_nx_s    = req_we;
         size_nx_s  = req_size;
         uns_nx_s   = req_unsigned;
         off_nx_s   = req_addr[1:0];
         adr_nx_s   = req_addr[ADDR_W+1:2];
         wdata_nx_s = req_wdata;
         err_nx_s   = req_err_s;
         cross_nx_s = req_cross_s;
         rd1_nx_s   = 32'd0;
         rd2_nx_s   = 32'd0;
      end else if ((state_r == BUS1) && wb_ack) begin
         rd1_nx_s = wb_dat_i;
      end else if ((state_r == BUS2) && wb_ack) begin
         rd2_nx_s = wb_dat_i;
      end else begin
         rd1_nx_s = rd1_r;
      end
   end

   // Next-state logic
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         IDLE: begin
            if (req_valid) state_nx_s = req_err_s ? RESP : BUS1;
            else           state_nx_s = IDLE;
         end
         BUS1: begin
`ifdef LSU_MISALIGN_SPLIT_EN
            if (wb_ack) state_nx_s = cross_r ? BUS2 : RESP;
            else        state_nx_s = BUS1;
`else
            if (wb_ack) state_nx_s = RESP;
            else        state_nx_s = BUS1;
`endif
         end
         BUS2: begin
`ifdef LSU_MISALIGN_SPLIT_EN
            if (wb_ack) state_nx_s = RESP;
            else        state_nx_s = BUS2;
`else
            state_nx_s = IDLE;
`endif
         end
         RESP:    state_nx_s = IDLE;
         default: state_nx_s = IDLE;
      endcase
   end

   // Output decode from the upcoming state so every port comes straight from a flop
   always_comb begin
      lane_s = {4'b0000, size_mask(size_nx_s)} << off_nx_s;
      wide_s = {32'd0, wdata_nx_s} << {off_nx_s, 3'b000};
      ld_s   = 32'({rd2_nx_s, rd1_nx_s} >> {off_nx_s, 3'b000});
      case (size_nx_s)
         2'd0:    ext_s = uns_nx_s ? {24'd0, ld_s[7:0]}   : {{24{ld_s[7]}}, ld_s[7:0]};
         2'd1:    ext_s = uns_nx_s ? {16'd0, ld_s[15:0]}  : {{16{ld_s[15]}}, ld_s[15:0]};
         2'd2:    ext_s = ld_s;
         default: ext_s = 32'd0;
      endcase
      req_ready_s  = 1'b0;
      resp_valid_s = 1'b0;
      resp_err_s   = 1'b0;
      resp_rdata_s = 32'd0;
      cyc_s        = 1'b0;
      stb_s        = 1'b0;
      we_s         = 1'b0;
      sel_s        = 4'b0000;
      adr_s        = '0;
      dat_s        = 32'd0;
      case (state_nx_s)
         IDLE: req_ready_s = 1'b1;
         BUS1: begin
            cyc_s = 1'b1;
            stb_s = 1'b1;
            we_s  = we_nx_s;
            sel_s = lane_s[3:0];
            adr_s = adr_nx_s;
            dat_s = wide_s[31:0];
         end
         BUS2: begin
            cyc_s = 1'b1;
            stb_s = 1'b1;
            we_s  = we_nx_s;
            sel_s = lane_s[7:4];
            adr_s = adr_nx_s + {{(ADDR_W-1){1'b0}}, 1'b1};
            dat_s = wide_s[63:32];
         end
         RESP: begin
            resp_valid_s = 1'b1;
            resp_err_s   = err_nx_s;
            resp_rdata_s = (we_nx_s || err_nx_s) ? 32'd0 : ext_s;
         end
         default: req_ready_s = 1'b0;
      endcase
   end

   // State, context and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= IDLE;
         we_r       <= 1'b0;
         size_r     <= 2'd0;
         uns_r      <= 1'b0;
         off_r      <= 2'd0;
         adr_r      <= '0;
         wdata_r    <= 32'd0;
         err_r      <= 1'b0;
         cross_r    <= 1'b0;
         rd1_r      <= 32'd0;
         rd2_r      <= 32'd0;
         req_ready  <= 1'b1;
         resp_valid <= 1'b0;
         resp_err   <= 1'b0;
         resp_rdata <= 32'd0;
         wb_cyc     <= 1'b0;
         wb_stb     <= 1'b0;
         wb_we      <= 1'b0;
         wb_sel     <= 4'b0000;
         wb_adr     <= '0;
         wb_dat_o   <= 32'd0;
      end else begin
         state_r    <= state_nx_s;
         we_r       <= we_nx_s;
         size_r     <= size_nx_s;
         uns_r      <= uns_nx_s;
         off_r      <= off_nx_s;
         adr_r      <= adr_nx_s;
         wdata_r    <= wdata_nx_s;
         err_r      <= err_nx_s;
         cross_r    <= cross_nx_s;
         rd1_r      <= rd1_nx_s;
         rd2_r      <= rd2_nx_s;
         req_ready  <= req_ready_s;
         resp_valid <= resp_valid_s;
         resp_err   <= resp_err_s;
         resp_rdata <= resp_rdata_s;
         wb_cyc     <= cyc_s;
         wb_stb     <= stb_s;
         wb_we      <= we_s;
         wb_sel     <= sel_s;
         wb_adr     <= adr_s;
         wb_dat_o   <= dat_s;
      end
   end

endmodule

// File: tb/tb_lsu_wb_master.sv
// Directed self-checking bench for lsu_wb_master with a byte-lane RAM model and programmable ack wait states.
module tb_lsu_wb_master;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0, req_ready, req_we = 1'b0, req_unsigned = 1'b0;
   logic [1:0]  req_size = 2'd0;
   logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;
   logic        resp_valid, resp_err;
   logic [31:0] resp_rdata;
   logic        wb_cyc, wb_stb, wb_we, wb_ack;
   logic [3:0]  wb_sel;
   logic [7:0]  wb_adr;
   logic [31:0] wb_dat_o, wb_dat_i;

   int total = 0;
   int bad = 0;

   lsu_wb_master #(.ADDR_W(8)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_size(req_size),
      .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_sel(wb_sel), .wb_adr(wb_adr),
      .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_ack(wb_ack)
   );

   always #5 clk = ~clk;

   // RAM model and bus monitor
   logic [31:0] mem [256];
   int          wait_req = 0;
   int          wait_cnt = 0;
   int          cyc_cnt = 0, stb_cnt = 0, adr_chg = 0, log_n = 0;
   logic        prev_pend = 1'b0;
   logic [7:0]  prev_adr = 8'd0;
   logic [7:0]  log_adr [64];
   logic [3:0]  log_sel [64];
   logic [31:0] log_dat [64];
   logic        log_we  [64];

   assign wb_ack   = wb_cyc && wb_stb && (wait_cnt == wait_req);
   assign wb_dat_i = mem[wb_adr];

   always @(posedge clk) begin
      if (rst) begin
         wait_cnt <= 0;
         mem[3]   <= 32'h0000_0000;
         mem[4]   <= 32'hDEAD_BEEF;
         mem[8]   <= 32'hCAFE_F00D;
         mem[255] <= 32'h0BAD_F00D;
      end else if (wb_cyc && wb_stb) begin
         if (wb_ack) begin
            wait_cnt <= 0;
            if (log_n < 64) begin
               log_adr[log_n] <= wb_adr;
               log_sel[log_n] <= wb_sel;
               log_dat[log_n] <= wb_dat_o;
               log_we[log_n]  <= wb_we;
            end
            log_n <= log_n + 1;
            if (wb_we) begin
               for (int b = 0; b < 4; b++)
                  if (wb_sel[b]) mem[wb_adr][8*b +: 8] <= wb_dat_o[8*b +: 8];
            end
         end else begin
            wait_cnt <= wait_cnt + 1;
         end
      end
      if (wb_cyc) cyc_cnt <= cyc_cnt + 1;
      if (wb_stb) stb_cnt <= stb_cnt + 1;
      if (prev_pend && wb_stb && (wb_adr != prev_adr)) adr_chg <= adr_chg + 1;
      prev_pend <= wb_stb && !wb_ack;
      prev_adr  <= wb_adr;
   end

   task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output int lat, output logic [31:0] rdata, output logic err,
                         output logic rdy_seen);
      bit done;
      @(negedge clk);
      req_we = we; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
      req_valid = 1'b1;
      for (int g = 0; g < 20 && !req_ready; g++) @(negedge clk);
      total++;
      if (req_ready !== 1'b1) begin bad++; $display("FAIL req_ready_timeout got=%b exp=1", req_ready); end
      @(posedge clk);
      #1 req_valid = 1'b0;
      lat = 1; rdy_seen = 1'b0; done = 1'b0;
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         rdy_seen = rdy_seen | req_ready;
         if (resp_valid === 1'b1) begin done = 1'b1; break; end
         @(posedge clk);
         lat++;
      end
      total++;
      if (!done) begin bad++; $display("FAIL resp_timeout addr=%h got=no_resp exp=resp", addr); end
      rdata = resp_rdata; err = resp_err;
      @(negedge clk);
      total++;
      if (resp_valid !== 1'b0) begin bad++; $display("FAIL resp_pulse_width got=%b exp=0", resp_valid); end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b exp=1", req_ready); end
      total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL rst_resp_valid got=%b exp=0", resp_valid); end
      total++; if (resp_err !== 1'b0) begin bad++; $display("FAIL rst_resp_err got=%b exp=0", resp_err); end
      total++; if (resp_rdata !== 32'd0) begin bad++; $display("FAIL rst_rdata got=%h exp=0", resp_rdata); end
      total++; if ({wb_cyc, wb_stb, wb_we} !== 3'b000) begin bad++; $display("FAIL rst_cyc_stb_we got=%b exp=000", {wb_cyc, wb_stb, wb_we}); end
      total++; if (wb_sel !== 4'd0) begin bad++; $display("FAIL rst_sel got=%b exp=0000", wb_sel); end
      total++; if (wb_adr !== 8'd0) begin bad++; $display("FAIL rst_adr got=%h exp=0", wb_adr); end
      total++; if (wb_dat_o !== 32'd0) begin bad++; $display("FAIL rst_dat_o got=%h exp=0", wb_dat_o); end
   endtask

   task automatic test_store_word();
      int lat, l0, c0; logic [31:0] rd; logic er, rs;
      l0 = log_n; c0 = cyc_cnt;
      do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, lat, rd, er, rs);
      total++; if (lat !== 2) begin bad++; $display("FAIL sw_latency got=%0d exp=2", lat); end
      total++; if (er !== 1'b0) begin bad++; $display("FAIL sw_err got=%b exp=0", er); end
      total++; if (rd !== 32'd0) begin bad++; $display("FAIL sw_rdata got=%h exp=0", rd); end
      total++; if (log_n - l0 !== 1) begin bad++; $display("FAIL sw_bus_cycles got=%0d exp=1", log_n - l0); end
      total++; if (cyc_cnt - c0 !== 1) begin bad++; $display("FAIL sw_cyc_len got=%0d exp=1", cyc_cnt - c0); end
      total++; if ({log_we[l0], log_adr[l0], log_sel[l0], log_dat[l0]} !== {1'b1, 8'd4, 4'b1111, 32'hDEADBEEF})
         begin bad++; $display("FAIL sw_bus got=we%b adr%h sel%b dat%h exp=we1 adr04 sel1111 datdeadbeef", log_we[l0], log_adr[l0], log_sel[l0], log_dat[l0]); end
   endtask

   task automatic test_loads();
      int lat, l0; logic [31:0] rd; logic er, rs;
      logic [1:0]  sz [4]  = '{2'd0, 2'd0, 2'd1, 2'd1};
      logic        un [4]  = '{1'b0, 1'b1, 1'b0, 1'b1};
      logic [31:0] ad [4]  = '{32'h13, 32'h13, 32'h12, 32'h10};
      logic [31:0] ex [4]  = '{32'hFFFFFFDE, 32'h000000DE, 32'hFFFFDEAD, 32'h0000BEEF};
      logic [3:0]  sl [4]  = '{4'b1000, 4'b1000, 4'b1100, 4'b0011};
      for (int i = 0; i < 4; i++) begin
         l0 = log_n;
         do_req(1'b0, sz[i], un[i], ad[i], 32'h0, lat, rd, er, rs);
         total++; if (rd !== ex[i]) begin bad++; $display("FAIL load%0d_rdata got=%h exp=%h", i, rd, ex[i]); end
         total++; if ({er, lat} !== {1'b0, 32'd2}) begin bad++; $display("FAIL load%0d_err_lat got=%b/%0d exp=0/2", i, er, lat); end
         total++; if ({log_we[l0], log_adr[l0], log_sel[l0]} !== {1'b0, 8'd4, sl[i]})
            begin bad++; $display("FAIL load%0d_bus got=we%b adr%h sel%b exp=we0 adr04 sel%b", i, log_we[l0], log_adr[l0], log_sel[l0], sl[i]); end
      end
      // top word of the RAM is still reachable by an aligned word load
      do_req(1'b0, 2'd2, 1'b0, 32'h3FC, 32'h0, lat, rd, er, rs);
      total++; if ({er, rd} !== {1'b0, 32'h0BADF00D}) begin bad++; $display("FAIL lw_top got=%b/%h exp=0/0badf00d", er, rd); end
   endtask

   task automatic test_misaligned_half();
      int lat, c0; logic [31:0] rd; logic er, rs;
      c0 = cyc_cnt;
      do_req(1'b0, 2'd1, 1'b0, 32'h11, 32'h0, lat, rd, er, rs);
`ifdef LSU_MISALIGN_SPLIT_EN
      total++; if ({er, rd} !== {1'b0, 32'hFFFFADBE}) begin bad++; $display("FAIL lh_odd got=%b/%h exp=0/ffffadbe", er, rd); end
      total++; if (log_sel[log_n-1] !== 4'b0110) begin bad++; $display("FAIL lh_odd_sel got=%b exp=0110", log_sel[log_n-1]); end
`else
      total++; if ({er, rd} !== {1'b1, 32'h0}) begin bad++; $display("FAIL lh_odd got=%b/%h exp=1/0", er, rd); end
      total++; if (cyc_cnt - c0 !== 0) begin bad++; $display("FAIL lh_odd_cyc got=%0d exp=0", cyc_cnt - c0); end
`endif
   endtask

   task automatic test_split();
      int lat, l0, c0; logic [31:0] rd; logic er, rs;
      l0 = log_n; c0 = cyc_cnt;
      do_req(1'b1, 2'd2, 1'b0, 32'h0E, 32'h11223344, lat, rd, er, rs);
`ifdef LSU_MISALIGN_SPLIT_EN
      total++; if ({er, lat} !== {1'b0, 32'd3}) begin bad++; $display("FAIL sw_split_err_lat got=%b/%0d exp=0/3", er, lat); end
      total++; if (cyc_cnt - c0 !== 2) begin bad++; $display("FAIL sw_split_cyc got=%0d exp=2", cyc_cnt - c0); end
      total++; if ({log_adr[l0], log_sel[l0], log_dat[l0]} !== {8'd3, 4'b1100, 32'h33440000})
         begin bad++; $display("FAIL sw_split_c1 got=adr%h sel%b dat%h exp=adr03 sel1100 dat33440000", log_adr[l0], log_sel[l0], log_dat[l0]); end
      total++; if ({log_adr[l0+1], log_sel[l0+1], log_dat[l0+1]} !== {8'd4, 4'b0011, 32'h00001122})
         begin bad++; $display("FAIL sw_split_c2 got=adr%h sel%b dat%h exp=adr04 sel0011 dat00001122", log_adr[l0+1], log_sel[l0+1], log_dat[l0+1]); end
      do_req(1'b0, 2'd2, 1'b0, 32'h0E, 32'h0, lat, rd, er, rs);
      total++; if ({er, rd, lat} !== {1'b0, 32'h11223344, 32'd3}) begin bad++; $display("FAIL lw_split got=%b/%h/%0d exp=0/11223344/3", er, rd, lat); end
`else
      total++; if ({er, rd} !== {1'b1, 32'h0}) begin bad++; $display("FAIL sw_split_err got=%b/%h exp=1/0", er, rd); end
      total++; if (cyc_cnt - c0 !== 0) begin bad++; $display("FAIL sw_split_cyc got=%0d exp=0", cyc_cnt - c0); end
`endif
   endtask

   task automatic test_errors();
      int lat, c0; logic [31:0] rd; logic er, rs;
      logic [1:0]  sz [3] = '{2'd3, 2'd2, 2'd2};
      logic [31:0] ad [3] = '{32'h20, 32'h400, 32'h3FE};
      for (int i = 0; i < 3; i++) begin
         c0 = cyc_cnt;
         do_req(1'b0, sz[i], 1'b0, ad[i], 32'h0, lat, rd, er, rs);
         total++; if ({er, rd} !== {1'b1, 32'h0}) begin bad++; $display("FAIL err%0d_resp got=%b/%h exp=1/0", i, er, rd); end
         total++; if (cyc_cnt - c0 !== 0) begin bad++; $display("FAIL err%0d_cyc got=%0d exp=0", i, cyc_cnt - c0); end
      end
   endtask

   task automatic test_wait_states();
      int lat, s0, a0; logic [31:0] rd; logic er, rs;
      wait_req = 3; s0 = stb_cnt; a0 = adr_chg;
      do_req(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, lat, rd, er, rs);
      wait_req = 0;
      total++; if (lat !== 5) begin bad++; $display("FAIL wait_latency got=%0d exp=5", lat); end
      total++; if ({er, rd} !== {1'b0, 32'hCAFEF00D}) begin bad++; $display("FAIL wait_rdata got=%b/%h exp=0/cafef00d", er, rd); end
      total++; if (rs !== 1'b0) begin bad++; $display("FAIL wait_ready_low got=%b exp=0", rs); end
      total++; if (stb_cnt - s0 !== 4) begin bad++; $display("FAIL wait_stb_len got=%0d exp=4", stb_cnt - s0); end
      total++; if (adr_chg - a0 !== 0) begin bad++; $display("FAIL wait_adr_stable got=%0d exp=0", adr_chg - a0); end
   endtask

   task automatic test_reset_mid_access();
      int l0, pulses;
      wait_req = 3;
      @(negedge clk);
      req_we = 1'b1; req_size = 2'd2; req_unsigned = 1'b0; req_wdata = 32'hA5A5A5A5;
`ifdef LSU_MISALIGN_SPLIT_EN
      req_addr = 32'h2E;
`else
      req_addr = 32'h24;
`endif
      req_valid = 1'b1;
      l0 = log_n;
      @(posedge clk);
      #1 req_valid = 1'b0;
`ifdef LSU_MISALIGN_SPLIT_EN
      // park in the second bus cycle before pulling reset
      for (int g = 0; g < 20 && !(log_n == l0 + 1 && wb_cyc); g++) @(negedge clk);
      total++; if (log_n - l0 !== 1) begin bad++; $display("FAIL mid_reach_bus2 got=%0d exp=1", log_n - l0); end
`else
      repeat (2) @(negedge clk);
`endif
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      wait_req = 0;
      total++; if ({wb_cyc, wb_stb} !== 2'b00) begin bad++; $display("FAIL mid_cyc_stb got=%b exp=00", {wb_cyc, wb_stb}); end
      total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL mid_ready got=%b exp=1", req_ready); end
      pulses = 0;
      for (int k = 0; k < 6; k++) begin
         if (resp_valid !== 1'b0) pulses++;
         @(negedge clk);
      end
      total++; if (pulses !== 0) begin bad++; $display("FAIL mid_no_resp got=%0d exp=0", pulses); end
   endtask

   initial begin
      test_reset();
      test_store_word();
      test_loads();
      test_misaligned_half();
      test_split();
      test_errors();
      test_wait_states();
      test_reset_mid_access();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout got=running exp=finished");
      $fatal(1, "global timeout");
   end
endmodule

// File: doc/lsu_wb_master.md
Name: lsu_wb_master

Overview:
- Load/store unit that sits directly upstream of the word-addressed, byte-selectable data RAM.
- Accepts CPU byte, halfword and word loads/stores on a byte address.
- Generates Wishbone-classic cycles (cyc/stb/we/sel/adr/dat) toward the RAM.
- Returns aligned, sign- or zero-extended load data to the core. Accesses that cross a word boundary are split into two bus cycles.

Parameters:
- ADDR_W, 8, width of the Wishbone word address; addressable space is 4*2^ADDR_W bytes.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  core request valid
- req_ready  out  1  LSU can accept a request this cycle
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  0 = byte, 1 = half, 2 = word; 3 is illegal
- req_unsigned  in  1  zero-extend load (LBU/LHU)
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- resp_valid  out  1  one-cycle pulse: access complete
- resp_rdata  out  32  extended load data; 0 for stores
- resp_err  out  1  qualifies resp_valid: access faulted
- wb_cyc  out  1  Wishbone cycle
- wb_stb  out  1  Wishbone strobe
- wb_we  out  1  Wishbone write enable
- wb_sel  out  4  byte lane selects
- wb_adr  out  ADDR_W  word address
- wb_dat_o  out  32  write data
- wb_dat_i  in  32  read data
- wb_ack  in  1  Wishbone acknowledge; may be combinational from cyc&&stb

Behaviour:
- Reset (rst high at posedge):
  - state=IDLE
  - req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0
  - wb_cyc=wb_stb=wb_we=0, wb_sel=0, wb_adr=0, wb_dat_o=0
  - Reset mid-operation drops the bus cycle immediately and emits no response.
- States: IDLE, BUS1, BUS2, RESP.
- IDLE:
  - req_ready=1; a request is accepted when req_valid && req_ready at posedge.
  - The request is registered; off=addr[1:0].
  - Crossing: half with off==3, or word with off!=0.
- Error check at accept. Any of the following → RESP with resp_err=1 and no bus cycle:
  - req_size==3
  - req_addr[31:ADDR_W+2] != 0
  - crossing access whose second word exceeds 2^ADDR_W-1 (no wrap)
- Bus cycle 1 (BUS1), entered the cycle after accept:
  - cyc=stb=1, adr=addr[ADDR_W+1:2]
  - sel = (size mask << off) truncated to 4 bits; masks are byte 0001, half 0011, word 1111
  - dat_o = wdata << 8*off
- BUS1 exit:
  - stb/cyc stay high until wb_ack is sampled high at posedge.
  - On ack, wb_dat_i is captured.
  - Next state is BUS2 if crossing, else RESP.
- Bus cycle 2 (BUS2):
  - cyc=stb=1, adr+1
  - sel = mask >> (4-off)
  - dat_o = wdata >> 8*(4-off)
  - On ack, wb_dat_i is captured; next state RESP.
  - cyc deasserts for at least one cycle between BUS1 and BUS2 is NOT required; cyc stays high across a split.
- RESP:
  - resp_valid=1 for exactly one cycle; req_ready=0; then IDLE.
  - New requests are accepted only in IDLE, so there is at most one outstanding request.
- Load assembly:
  - Combined 64-bit value {word2,word1} >> 8*off.
  - Low 8 or 16 bits are sign-extended unless req_unsigned; for words the low 32 bits are taken.
- resp_rdata=0 when the request is a store or resp_err=1.
- Latency with zero-wait ack:
  - aligned: accept at edge N, resp_valid during cycle N+2
  - split: resp_valid during cycle N+3
  - Each wait state adds 1.
- wb_we equals the registered req_we throughout bus cycles and is 0 otherwise.

Optional Feature:
- Macro LSU_MISALIGN_SPLIT_EN.
- Defined: crossing accesses are split into two bus cycles as described above.
- Undefined: BUS2 is not built. Any crossing access, or any misaligned half/word (half with off odd, word with off!=0), goes to RESP with resp_err=1 and no bus cycle.

Test Plan:
- Store word: SW addr 0x10, data 0xDEADBEEF → one bus cycle adr=4, sel=1111, dat_o=0xDEADBEEF, we=1; resp_valid 2 cycles after accept, err=0.
- Loads with extension: memory word 4 = 0xDEADBEEF.
  - LB 0x13 → rdata 0xFFFFFFDE
  - LBU 0x13 → 0x000000DE
  - LH 0x12 → 0xFFFFDEAD
  - For each: sel on the bus is 1111-masked to the correct lanes, i.e. 1000 for the bytes and 1100 for the half.
- Split word (macro defined): SW 0x0E data 0x11223344.
  - Cycle 1: adr=3, sel=1100, dat_o=0x33440000.
  - Cycle 2: adr=4, sel=0011, dat_o=0x00001122.
  - Then LW 0x0E returns 0x11223344, resp 3 cycles after accept.
- Errors:
  - req_size=3 → resp_err=1, no wb_cyc.
  - addr 0x400 with ADDR_W=8 → resp_err=1, no wb_cyc.
  - LW 0x3FE → resp_err=1, no wb_cyc (second word out of range).
- Wait states: wb_ack held low 3 cycles on LW 0x20 → stb stays high and adr stable; resp_valid 5 cycles after accept; req_ready low throughout.
- Reset mid-access: assert rst while in BUS2 → next cycle cyc=stb=0, req_ready=1, no resp_valid pulse.
